// File: rtl/bch_err_injector.sv
// bch_err_injector
//   Flips a runtime-selected number of distinct, pseudo-randomly chosen bit
//   positions in one CW_WIDTH-bit codeword. It sits between the BCH encoder
//   and the BCH decoder.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   seed_load, seed    reload the LFSR (a seed of 0 selects LFSR_SEED)
//   in_valid/in_ready  codeword handshake; in_data and num_err are sampled on transfer
//   out_valid/out_ready result handshake; out_data, out_mask, out_err_cnt, out_timeout
//   busy               high whenever a word is in flight
module bch_err_injector #(
  parameter int unsigned CW_WIDTH  = 15,
  parameter int unsigned MAX_ERR   = 4,
  parameter int unsigned MAX_TRIES = 256,
  parameter logic [31:0] LFSR_SEED = 32'hA1B2C3D4,
  localparam int unsigned IDX_W    = $clog2(CW_WIDTH),
  localparam int unsigned NE_W     = $clog2(MAX_ERR + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                seed_load,
  input  logic [31:0]         seed,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW_WIDTH-1:0] in_data,
  input  logic [NE_W-1:0]     num_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW_WIDTH-1:0] out_data,
  output logic [CW_WIDTH-1:0] out_mask,
  output logic [NE_W-1:0]     out_err_cnt,
  output logic                out_timeout,
  output logic                busy
);

  localparam int unsigned      TRY_W     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [IDX_W:0]   CW_LIM    = (IDX_W + 1)'(CW_WIDTH);
  localparam logic [NE_W-1:0]  MAX_NE    = NE_W'(MAX_ERR);
  localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [31:0]      POLY_MASK = 32'h80200003;

  typedef enum logic [1:0] {S_IDLE, S_INJECT, S_OUT} state_t;

  state_t              state_q, state_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [CW_WIDTH-1:0] word_q, word_d;
  logic [CW_WIDTH-1:0] mask_q, mask_d;
  logic [NE_W-1:0]     cnt_q, cnt_d;
  logic [NE_W-1:0]     target_q, target_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic                timeout_q, timeout_d;

  logic [IDX_W-1:0]    idx;
  logic                idx_ok;
  logic [CW_WIDTH-1:0] hit;
  logic                accept;
  logic [NE_W-1:0]     cnt_inc;

  // Galois LFSR runs every cycle regardless of state; a seed load wins.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY_MASK : '0);
    if (seed_load) begin
      lfsr_d = (seed == '0) ? LFSR_SEED : seed;
    end
  end

  assign idx    = lfsr_q[IDX_W-1:0];
  assign idx_ok = ({1'b0, idx} < CW_LIM);

  // One-hot of the candidate position; all-zero when idx is out of range.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < CW_WIDTH; i++) begin
      if (idx_ok && (idx == IDX_W'(i))) begin
        hit[i] = 1'b1;
      end
    end
  end

  assign accept  = (|hit) && !(|(hit & mask_q));
  assign cnt_inc = cnt_q + NE_W'(1);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    tries_d   = tries_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d    = in_data;
          target_d  = (num_err > MAX_NE) ? MAX_NE : num_err;
          mask_d    = '0;
          cnt_d     = '0;
          tries_d   = '0;
          timeout_d = 1'b0;
          // Clamped target is zero exactly when num_err is zero (MAX_ERR >= 1).
          state_d   = (num_err == '0) ? S_OUT : S_INJECT;
        end
      end
      S_INJECT: begin
        tries_d = tries_q + TRY_W'(1);
        if (accept) begin
          word_d = word_q ^ hit;
          mask_d = mask_q | hit;
          cnt_d  = cnt_inc;
        end
        if (accept && (cnt_inc == target_q)) begin
          state_d = S_OUT;
        end else if (tries_q == LAST_TRY) begin
          state_d   = S_OUT;
          timeout_d = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d   = S_IDLE;
          timeout_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      word_q    <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      target_q  <= '0;
      tries_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      word_q    <= word_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      tries_q   <= tries_d;
      timeout_q <= timeout_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_OUT);
  assign busy        = (state_q != S_IDLE);
  assign out_data    = word_q;
  assign out_mask    = mask_q;
  assign out_err_cnt = cnt_q;
  assign out_timeout = timeout_q;

endmodule

// File: doc/bch_err_injector.md
Name: bch_err_injector

Overview:
- Parametrised successor to the fixed 14-bit random error generator in the BCH transmission chain.
- Accepts one codeword of CW_WIDTH bits over a valid/ready handshake.
- Flips a runtime-selected number of distinct, pseudo-randomly chosen bit positions (up to MAX_ERR).
- Returns the corrupted word, the error mask and the error count over a second valid/ready handshake.
- Sits between the BCH encoder and decoder.

Parameters:
- CW_WIDTH, 15: codeword width in bits; legal range 2..1023.
- MAX_ERR, 4: maximum errors injected per word; must satisfy 1 <= MAX_ERR <= CW_WIDTH.
- MAX_TRIES, 256: per-word candidate limit before abort; minimum 1.
- LFSR_SEED, 32'hA1B2C3D4: LFSR value after reset; must be nonzero.
- Derived localparams: IDX_W = $clog2(CW_WIDTH); NE_W = $clog2(MAX_ERR+1).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- seed_load  in  1  load LFSR from seed this cycle
- seed  in  32  LFSR seed; 0 substitutes LFSR_SEED
- in_valid  in  1  codeword offered
- in_ready  out  1  block can accept a codeword
- in_data  in  CW_WIDTH  clean codeword
- num_err  in  NE_W  requested error count, sampled with in_data
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  CW_WIDTH  corrupted codeword
- out_mask  out  CW_WIDTH  positions flipped
- out_err_cnt  out  NE_W  number of bits flipped
- out_timeout  out  1  MAX_TRIES reached before target
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values:
  - state = IDLE; in_ready = 1.
  - out_valid, out_data, out_mask, out_err_cnt, out_timeout and busy all 0.
  - LFSR = LFSR_SEED; internal counters 0.
- Reset asserted mid-operation aborts the word silently; nothing is emitted.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (shift right; xor mask 32'h80200003 when bit 0 = 1).
  - Advances every cycle in every state.
  - seed_load has priority over advance in any state and does not disturb an in-flight word.
- Candidate index: idx = lfsr[IDX_W-1:0].
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data into the working word, target = min(num_err, MAX_ERR), mask = 0, cnt = 0, tries = 0.
  - Next state: OUT if target == 0, else INJECT.
- State INJECT (one candidate per cycle):
  - tries increments each cycle.
  - Accept the candidate iff idx < CW_WIDTH and mask[idx] == 0. On accept: word[idx] flips, mask[idx] = 1, cnt++.
  - Rejected candidates change nothing except tries.
  - Go to OUT when cnt reaches target, counting the current accept.
  - Also go to OUT when tries == MAX_TRIES - 1 and the target is not reached; set out_timeout = 1.
- State OUT:
  - out_valid = 1; out_data = word, out_mask = mask, out_err_cnt = cnt, all held stable until out_valid & out_ready.
  - After that handshake, next state is IDLE. out_valid drops and out_timeout clears in the same edge.
- in_ready = 0 in INJECT and OUT; no input is accepted until the result is consumed.
- Latency:
  - Target 0: out_valid rises the cycle after acceptance.
  - Target n with no rejections: out_valid rises n+1 cycles after acceptance.
  - Worst case: MAX_TRIES+1 cycles.
- Invariants, checked at every output transfer:
  - out_data == captured in_data ^ out_mask.
  - popcount(out_mask) == out_err_cnt <= target.
  - out_timeout == (out_err_cnt < target).
- Simultaneous events: out_ready asserted with out_valid in OUT completes the transfer. in_valid in that same cycle is not accepted (in_ready = 0) and is taken in the following IDLE cycle.
- Determinism: the same seed and the same cycle timing from reset reproduce an identical out_mask sequence.

Test Plan:
- Zero errors: num_err=0, in_data=15'h1234, out_ready=1 -> out_valid the next cycle; out_data=15'h1234, out_mask=0, out_err_cnt=0, out_timeout=0.
- Nominal: num_err=4, in_data=0 -> out_err_cnt=4, popcount(out_mask)=4, out_data==out_mask, out_timeout=0, no mask bit at or above 15. Repeat 1000 words with the invariants checked.
- Clamp: num_err=7 with MAX_ERR=4 -> out_err_cnt=4.
- Full saturation: CW_WIDTH=15, MAX_ERR=15, MAX_TRIES=4096, num_err=15, in_data=15'h5555 -> out_mask=15'h7FFF, out_data=15'h2AAA.
- Timeout: same configuration with MAX_TRIES=8 -> out_timeout=1 and out_err_cnt<=8 after exactly 9 cycles.
- Backpressure and reset: hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0; a second in_valid is not consumed. Then pulse rstn low mid-INJECT -> all outputs at reset values, in_ready=1. Repeat from reset with seed_load and seed=0 -> the mask matches the LFSR_SEED run.
